// File: rtl/chan_scan_mux_if.sv
// ---------------------------------------------------------------------------
// chan_scan_mux_if
//
// Bundle of the data-path and handshake signals of chan_scan_mux.
//
// Handshake: a word moves from the mux to the consumer on a rising clock edge
// where out_valid && out_ready. out_valid never depends combinationally on
// out_ready. While out_valid=1 and out_ready=0, out_data/out_ch/out_valid are
// held stable. out_ready is a don't-care while out_valid=0.
//
// Signals:
//   in_data   NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   in_valid  NCH        per-channel data-valid
//   mode      1          0 = manual select, 1 = auto-scan
//   sel       SELW       manual channel select
//   out_data  WIDTH      registered selected data
//   out_ch    SELW       channel index out_data came from
//   out_valid 1          out_data holds a word
//   out_ready 1          consumer accepts the word
//
// Modports:
//   master - the environment (sources + consumer)
//   slave  - the mux itself
//
// Parameters must match the ones given to chan_scan_mux.
// ---------------------------------------------------------------------------
interface chan_scan_mux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data,
        output in_valid,
        output mode,
        output sel,
        output out_ready,
        input  out_data,
        input  out_ch,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  mode,
        input  sel,
        input  out_ready,
        output out_data,
        output out_ch,
        output out_valid
    );
endinterface

// File: rtl/chan_scan_mux.sv
// ---------------------------------------------------------------------------
// chan_scan_mux
//
// Selects one of NCH channels of WIDTH bits into a single registered output
// word with a valid/ready handshake towards a consumer that may stall.
//
// Two modes, chosen by bus.mode and tracked by a two-state FSM:
//   MAN  - channel bus.sel is captured every free cycle.
//   SCAN - channels are visited round-robin; DWELL words are taken from a
//          channel before moving on. A channel with no valid data costs one
//          bubble cycle and the scan moves past it.
//
// The capture made on an edge always follows the state held before that
// edge, so the edge that switches MAN->SCAN still captures with MAN rules
// and merely clears the scan pointer and dwell counter.
//
// Handshake: the output register is "free" when it is empty or being read
// (!out_valid || out_ready). Only a free register loads a new word; while
// stalled, out_data/out_ch/out_valid and the scan pointer/counter all hold.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   bus        chan_scan_mux_if slave modport (data, valid, mode, sel,
//              out_data, out_ch, out_valid, out_ready)
//   dbg_state  current FSM state (0 = MAN, 1 = SCAN)
//   dbg_ptr    scan pointer
//   dbg_cnt    dwell counter
//
// Parameters:
//   WIDTH  data width per channel
//   NCH    number of channels, 2..16
//   SELW   select/pointer width, 2**SELW >= NCH
//   DWELL  words taken from one channel before the scan advances, >= 1
// ---------------------------------------------------------------------------
module chan_scan_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    chan_scan_mux_if.slave          bus,
    output logic                    dbg_state,
    output logic [SELW-1:0]         dbg_ptr,
    output logic [$clog2(DWELL):0]  dbg_cnt
);

    // Dwell counter is one bit wider than needed to hold DWELL-1 so the
    // terminal compare never has to deal with a truncated constant.
    localparam int CW = $clog2(DWELL) + 1;

    // Number of addressable select codes; codes >= NCH are out of range.
    localparam int NSLOT = 2 ** SELW;

    localparam logic [SELW-1:0] LAST_PTR  = SELW'(NCH - 1);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(DWELL - 1);
    localparam logic [SELW:0]   NCH_LIMIT = (SELW + 1)'(NCH);

    typedef enum logic {
        ST_MAN  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Channel view padded to the full select range. Unused slots read as
    // zero data / not valid, which keeps every index in range for any sel.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] ch_data  [NSLOT];
    logic [NSLOT-1:0] ch_valid;

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < NCH) begin : g_used
            assign ch_data[k]  = bus.in_data[k*WIDTH +: WIDTH];
            assign ch_valid[k] = bus.in_valid[k];
        end else begin : g_unused
            assign ch_data[k]  = '0;
            assign ch_valid[k] = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;

    logic             reg_free;
    logic             sel_ok;
    logic             scan_entry;
    logic [SELW-1:0]  ptr_adv;

    assign reg_free   = !out_valid_q || bus.out_ready;
    assign sel_ok     = ({1'b0, bus.sel} < NCH_LIMIT);
    assign scan_entry = (state_q == ST_MAN) && (state_d == ST_SCAN);

    // Pointer wraps at NCH-1 rather than at 2**SELW-1, so it never reaches
    // an out-of-range channel.
    assign ptr_adv = (ptr_q == LAST_PTR) ? '0 : ptr_q + SELW'(1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_MAN;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and capture logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;

        // The state simply tracks the mode input.
        case (state_q)
            ST_MAN:  if (bus.mode)  state_d = ST_SCAN;
            ST_SCAN: if (!bus.mode) state_d = ST_MAN;
            default: state_d = ST_MAN;
        endcase

        if (reg_free) begin
            case (state_q)
                ST_MAN: begin
                    if (sel_ok) begin
                        out_data_d  = ch_data[bus.sel];
                        out_ch_d    = bus.sel;
                        out_valid_d = ch_valid[bus.sel];
                    end else begin
                        // Out-of-range select: drop valid, keep last word.
                        out_valid_d = 1'b0;
                    end
                end

                ST_SCAN: begin
                    if (ch_valid[ptr_q]) begin
                        out_data_d  = ch_data[ptr_q];
                        out_ch_d    = ptr_q;
                        out_valid_d = 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            ptr_d = ptr_adv;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        // Empty channel: one bubble, then move on. The last
                        // word and its channel index are left in place.
                        out_valid_d = 1'b0;
                        ptr_d       = ptr_adv;
                        cnt_d       = '0;
                    end
                end

                default: begin
                    out_valid_d = 1'b0;
                end
            endcase
        end

        // Entering scan always starts from channel 0 with a fresh dwell,
        // independent of whether the output register was free.
        if (scan_entry) begin
            ptr_d = '0;
            cnt_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

    assign dbg_state = (state_q == ST_SCAN);
    assign dbg_ptr   = ptr_q;
    assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_chan_scan_mux
//
// Two instances: a 4-channel mux and a 3-channel mux (out-of-range select
// and scan wrap), both with DWELL=2, sharing clock and reset.
// Each cycle the driver sets inputs, pushes the expected {valid, ch, data}
// to the scoreboard queue, and after the edge the oldest entry is popped and
// compared with the selected instance's outputs.
// ---------------------------------------------------------------------------
module tb_chan_scan_mux;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] exp_q[$];

    chan_scan_mux_if #(.WIDTH(8), .NCH(4), .SELW(2)) if4 ();
    chan_scan_mux_if #(.WIDTH(8), .NCH(3), .SELW(2)) if3 ();

    logic       dbg_state4, dbg_state3;
    logic [1:0] dbg_ptr4, dbg_ptr3;
    logic [1:0] dbg_cnt4, dbg_cnt3;

    chan_scan_mux #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(2)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .bus       (if4),
        .dbg_state (dbg_state4),
        .dbg_ptr   (dbg_ptr4),
        .dbg_cnt   (dbg_cnt4)
    );

    chan_scan_mux #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(2)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .bus       (if3),
        .dbg_state (dbg_state3),
        .dbg_ptr   (dbg_ptr3),
        .dbg_cnt   (dbg_cnt3)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // ---------------- check / driver tasks ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Push the expected output for the coming edge, wait for it, pop and
    // compare against the chosen instance.
    task automatic run_cycle(input int dut, input logic ev, input logic [1:0] ech,
                             input logic [7:0] ed, input string tag);
        logic [10:0] e;
        logic [10:0] g;
        exp_q.push_back({ev, ech, ed});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (dut == 4) g = {if4.out_valid, if4.out_ch, if4.out_data};
        else          g = {if3.out_valid, if3.out_ch, if3.out_data};
        check_eq({tag, ".valid"}, 32'(g[10]),   32'(e[10]));
        check_eq({tag, ".ch"},    32'(g[9:8]),  32'(e[9:8]));
        check_eq({tag, ".data"},  32'(g[7:0]),  32'(e[7:0]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] r_sel;
        logic [3:0] r_valid;
        logic [1:0] ch;

        reset = 1'b1;
        if4.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        if4.in_valid = 4'hF;
        if4.mode = 1'b0;
        if4.sel = 2'd0;
        if4.out_ready = 1'b1;
        if3.in_data = {8'hB2, 8'hB1, 8'hB0};
        if3.in_valid = 3'b111;
        if3.mode = 1'b0;
        if3.sel = 2'd0;
        if3.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.valid", 32'(if4.out_valid), 32'd0);
        check_eq("rst.data",  32'(if4.out_data),  32'd0);
        check_eq("rst.ch",    32'(if4.out_ch),    32'd0);
        check_eq("rst.state", 32'(dbg_state4),    32'd0);
        check_eq("rst.ptr",   32'(dbg_ptr4),      32'd0);
        check_eq("rst.cnt",   32'(dbg_cnt4),      32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Manual select
        if4.sel = 2'd2;
        run_cycle(4, 1'b1, 2'd2, 8'hA2, "man.sel2");
        if4.sel = 2'd0;
        run_cycle(4, 1'b1, 2'd0, 8'hA0, "man.sel0");

        // Backpressure
        if4.sel = 2'd2;
        run_cycle(4, 1'b1, 2'd2, 8'hA2, "bp.load");
        if4.out_ready = 1'b0;
        if4.sel = 2'd1;
        for (int i = 0; i < 3; i++)
            run_cycle(4, 1'b1, 2'd2, 8'hA2, $sformatf("bp.hold%0d", i));
        if4.out_ready = 1'b1;
        run_cycle(4, 1'b1, 2'd1, 8'hA1, "bp.release");

        // Random manual traffic
        for (int i = 0; i < 20; i++) begin
            r_sel   = 2'($urandom_range(0, 3));
            r_valid = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++)
                if4.in_data[k*8 +: 8] = 8'($urandom_range(0, 255));
            if4.in_valid = r_valid;
            if4.sel = r_sel;
            run_cycle(4, r_valid[r_sel], r_sel, if4.in_data[r_sel*8 +: 8],
                      $sformatf("rnd%0d", i));
        end

        // Scan, all channels valid
        if4.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        if4.in_valid = 4'hF;
        if4.sel = 2'd1;
        if4.mode = 1'b1;
        run_cycle(4, 1'b1, 2'd1, 8'hA1, "scan.entry");
        for (int i = 0; i < 10; i++) begin
            ch = 2'((i / 2) % 4);
            run_cycle(4, 1'b1, ch, 8'hA0 + 8'(ch), $sformatf("scan.seq%0d", i));
        end

        // Reset in the middle of a running scan
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstmid.valid", 32'(if4.out_valid), 32'd0);
        check_eq("rstmid.data",  32'(if4.out_data),  32'd0);
        check_eq("rstmid.ch",    32'(if4.out_ch),    32'd0);
        if4.mode = 1'b0;
        if4.sel = 2'd1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_cycle(4, 1'b1, 2'd1, 8'hA1, "rstmid.first");

        // Scan with empty channels 0 and 2, including a stall mid-dwell
        if4.in_valid = 4'b1010;
        if4.mode = 1'b1;
        run_cycle(4, 1'b1, 2'd1, 8'hA1, "skip.entry");
        run_cycle(4, 1'b0, 2'd1, 8'hA1, "skip.bub0");
        run_cycle(4, 1'b1, 2'd1, 8'hA1, "skip.c1a");
        run_cycle(4, 1'b1, 2'd1, 8'hA1, "skip.c1b");
        run_cycle(4, 1'b0, 2'd1, 8'hA1, "skip.bub2");
        run_cycle(4, 1'b1, 2'd3, 8'hA3, "skip.c3a");
        run_cycle(4, 1'b1, 2'd3, 8'hA3, "skip.c3b");
        run_cycle(4, 1'b0, 2'd3, 8'hA3, "skip.bub0b");
        run_cycle(4, 1'b1, 2'd1, 8'hA1, "skip.c1c");
        if4.out_ready = 1'b0;
        if4.in_data = {4{8'hFF}};
        if4.sel = 2'd2;
        for (int i = 0; i < 2; i++) begin
            run_cycle(4, 1'b1, 2'd1, 8'hA1, $sformatf("skip.stall%0d", i));
            check_eq($sformatf("skip.stall%0d.ptr", i), 32'(dbg_ptr4), 32'd1);
            check_eq($sformatf("skip.stall%0d.cnt", i), 32'(dbg_cnt4), 32'd1);
        end
        if4.out_ready = 1'b1;
        if4.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        run_cycle(4, 1'b1, 2'd1, 8'hA1, "skip.c1d");
        run_cycle(4, 1'b0, 2'd1, 8'hA1, "skip.bub2b");
        run_cycle(4, 1'b1, 2'd3, 8'hA3, "skip.c3c");

        // Three-channel instance: out-of-range select and scan wrap
        if3.sel = 2'd2;
        run_cycle(3, 1'b1, 2'd2, 8'hB2, "n3.sel2");
        if3.sel = 2'd3;
        run_cycle(3, 1'b0, 2'd2, 8'hB2, "n3.sel3a");
        run_cycle(3, 1'b0, 2'd2, 8'hB2, "n3.sel3b");
        if3.sel = 2'd0;
        if3.mode = 1'b1;
        run_cycle(3, 1'b1, 2'd0, 8'hB0, "n3.entry");
        for (int i = 0; i < 8; i++) begin
            ch = 2'((i / 2) % 3);
            run_cycle(3, 1'b1, ch, 8'hB0 + 8'(ch), $sformatf("n3.scan%0d", i));
        end

        check_eq("sb.empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/chan_scan_mux.md
Name: chan_scan_mux

Overview:
Parametrised successor to the team's 3:1 select mux. It selects one of NCH channels of WIDTH bits into a registered output stage with a valid/ready handshake. It has two modes: manual select, and an auto-scan mode that round-robins channels with a programmable dwell. It sits between parallel data sources and a single downstream consumer that can stall.

Parameters:
WIDTH, 8, data width per channel
NCH, 4, number of input channels (2..16)
SELW, 2, select/pointer width; must satisfy 2**SELW >= NCH
DWELL, 2, transfers taken from one channel before scan advances (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel data-valid
mode  input  1  0 = manual, 1 = scan
sel  input  SELW  manual channel select
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  channel index that out_data came from
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts when out_valid && out_ready

Behaviour:
- Reset (async, immediate): out_data=0, out_ch=0, out_valid=0, state=MAN, ptr=0, cnt=0. Reset mid-transfer discards held data. No output on the first edge after release unless the capture rules below fire.
- FSM, two states: MAN and SCAN. state follows mode on each edge: MAN->SCAN when mode=1; SCAN->MAN when mode=0.
- On the MAN->SCAN edge, ptr and cnt clear to 0. The capture on that same edge follows MAN rules. The capture on any edge uses the state held before the edge.
- Output register "free" = !out_valid || out_ready. When not free, out_data, out_ch, out_valid, ptr and cnt all hold; in_data/sel changes are ignored.
- Latency: 1 cycle, input to out_data. Throughput: 1 transfer per cycle when out_ready=1.
- MAN, register free, capture channel sel:
  - out_data <= in_data[sel], out_ch <= sel, out_valid <= in_valid[sel].
  - sel >= NCH: out_valid <= 0, out_data/out_ch hold.
- SCAN, register free:
  - If in_valid[ptr]=1: capture channel ptr (out_data, out_ch=ptr, out_valid=1).
    - If cnt==DWELL-1: ptr advances and cnt=0.
    - Otherwise: cnt+1.
  - If in_valid[ptr]=0: out_valid <= 0 (one bubble), ptr advances, cnt=0.
- ptr advance wraps NCH-1 -> 0. ptr never holds a value >= NCH.
- cnt width: clog2(DWELL)+1 bits; no overflow.
- SCAN->MAN: ptr and cnt hold (unused) until the next SCAN entry clears them.
- out_ready is ignored while out_valid=0.

Test Plan:
1. Reset mid-op: scan running with out_valid=1, assert reset between edges -> out_valid=0, out_data=0, out_ch=0 immediately; after release with mode=0, sel=1, all valid -> out_data=ch1 one edge later.
2. Manual: ch0..3 = 8'hA0..8'hA3, in_valid=4'hF, sel=2, out_ready=1 -> next edge out_data=8'hA2, out_ch=2, out_valid=1; sel=0 -> 8'hA0 next edge.
3. Backpressure: holding 8'hA2, out_ready=0 for 3 cycles while sel=1 -> out_data stays 8'hA2, out_valid=1; raise out_ready -> next edge 8'hA1, out_ch=1.
4. Scan, DWELL=2, in_valid=4'hF, out_ready=1: mode=1 -> one MAN capture, then out_ch sequence 0,0,1,1,2,2,3,3,0,0 on consecutive edges, out_valid=1 throughout.
5. Scan skip: in_valid=4'b1010 -> out_valid 0 (ch0 bubble), ch1, ch1, out_valid 0 (ch2 bubble), ch3, ch3, repeating; stall mid-dwell with out_ready=0 -> ptr/cnt frozen, sequence resumes unchanged.
6. Out-of-range select, NCH=3, SELW=2: sel=3 in MAN -> out_valid=0 and out_data holds its previous value; scan with NCH=3 wraps 2->0, never emits out_ch=3.
